// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the fetch-stage program-counter unit.
//   - default width / vector / step / return-stack depth constants
//   - next-PC select encoding (pc_sel_e)
//   - ras_ptr_w(): pointer width for a return stack of a given depth
package pc_pkg;

    localparam int              PC_W_DEF      = 16;
    localparam logic [15:0]     RESET_VEC_DEF = 16'h0000;
    localparam logic [15:0]     TRAP_VEC_DEF  = 16'h0100;
    localparam int              INC_DEF       = 1;
    localparam int              RAS_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_BR   = 3'd1,
        SEL_JMP  = 3'd2,
        SEL_RET  = 3'd3,
        SEL_TRAP = 3'd4,
        SEL_RFE  = 3'd5
    } pc_sel_e;

    // A depth-1 stack would need a zero-width pointer; keep at least one bit.
    function automatic int ras_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack (LIFO).
//   CLK        clock, all updates on posedge
//   RESET      synchronous active-high reset (empties stack, clears ERR)
//   PUSH       push PUSH_DATA (overwrites the oldest entry when full)
//   POP        pop the top entry (no-op apart from ERR when empty)
//   PUSH_DATA  value to push
//   TOP        current top entry (combinational read of registered storage)
//   EMPTY      stack holds 0 entries
//   FULL       stack holds DEPTH entries
//   ERR        sticky overflow/underflow flag, cleared only by RESET
// DEPTH must be a power of two so the pointer wraps naturally.
// PUSH and POP are never requested together by pc_unit; PUSH takes precedence.
module pc_ras
    import pc_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH_DEF,
    parameter int W     = PC_W_DEF
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         PUSH,
    input  logic         POP,
    input  logic [W-1:0] PUSH_DATA,
    output logic [W-1:0] TOP,
    output logic         EMPTY,
    output logic         FULL,
    output logic         ERR
);

    localparam int PTR_W = ras_ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] top_ptr;
    logic [PTR_W-1:0] push_ptr;
    logic [CNT_W-1:0] count;
    logic             err_q;

    // top_ptr addresses the newest entry; a push writes one slot above it,
    // which when full is exactly the oldest entry being discarded.
    assign push_ptr = top_ptr + 1'b1;

    always_ff @(posedge CLK) begin
        if (!RESET && PUSH) begin
            mem[push_ptr] <= PUSH_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            top_ptr <= '0;
            count   <= '0;
            err_q   <= 1'b0;
        end else if (PUSH) begin
            top_ptr <= push_ptr;
            if (count == CNT_MAX) begin
                err_q <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end else if (POP) begin
            if (count == '0) begin
                err_q <= 1'b1;
            end else begin
                top_ptr <= top_ptr - 1'b1;
                count   <= count - 1'b1;
            end
        end
    end

    assign TOP   = mem[top_ptr];
    assign EMPTY = (count == '0);
    assign FULL  = (count == CNT_MAX);
    assign ERR   = err_q;

endmodule

// File: rtl/pc_unit.sv
// pc_unit: parametrised program counter for the fetch stage.
//   CLK         clock, all updates on posedge
//   RESET       synchronous active-high reset, overrides everything
//   PC_EN       advance enable; 0 holds PC, RAS and ignores all requests
//   BR_TAKEN    PC-relative branch, BR_OFFSET is two's complement
//   JMP         absolute jump to JMP_TARGET; with CALL also pushes PC+INC
//   RET         pop return address into PC (PC+INC on underflow)
//   PC          registered current PC
//   NPC         combinational next PC (the value PC takes at the next edge)
//   RAS_EMPTY / RAS_FULL / RAS_ERR   return-stack status, ERR is sticky
// Optional (macro PC_TRAP_EN): TRAP, RFE inputs, EPC output, TRAP_VEC
// parameter. Priority is TRAP > RFE > RET > JMP > BR_TAKEN > sequential.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF),
`ifdef PC_TRAP_EN
    parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'(TRAP_VEC_DEF),
`endif
    parameter int              INC       = INC_DEF,
    parameter int              RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            PC_EN,
    input  logic            BR_TAKEN,
    input  logic [PC_W-1:0] BR_OFFSET,
    input  logic            JMP,
    input  logic [PC_W-1:0] JMP_TARGET,
    input  logic            CALL,
    input  logic            RET,
`ifdef PC_TRAP_EN
    input  logic            TRAP,
    input  logic            RFE,
    output logic [PC_W-1:0] EPC,
`endif
    output logic [PC_W-1:0] PC,
    output logic [PC_W-1:0] NPC,
    output logic            RAS_EMPTY,
    output logic            RAS_FULL,
    output logic            RAS_ERR
);

    localparam logic [PC_W-1:0] STEP = PC_W'(INC);

    pc_sel_e         sel;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] npc;
    logic [PC_W-1:0] ras_top;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_empty;

`ifdef PC_TRAP_EN
    logic [PC_W-1:0] epc_q;
`endif

    // Later assignments override earlier ones, so the list runs from
    // lowest to highest priority.
    always_comb begin
        sel = SEL_SEQ;
        if (BR_TAKEN) sel = SEL_BR;
        if (JMP)      sel = SEL_JMP;
        if (RET)      sel = SEL_RET;
`ifdef PC_TRAP_EN
        if (RFE)      sel = SEL_RFE;
        if (TRAP)     sel = SEL_TRAP;
`endif
    end

    assign pc_seq = pc_q + STEP;

    // NPC folds in reset and stall so that PC is always loaded from it.
    always_comb begin
        npc = pc_seq;
        if (RESET) begin
            npc = RESET_VEC;
        end else if (!PC_EN) begin
            npc = pc_q;
        end else begin
            case (sel)
                SEL_SEQ:  npc = pc_seq;
                SEL_BR:   npc = pc_q + BR_OFFSET;
                SEL_JMP:  npc = JMP_TARGET;
                SEL_RET:  npc = ras_empty ? pc_seq : ras_top;
`ifdef PC_TRAP_EN
                SEL_TRAP: npc = TRAP_VEC;
                SEL_RFE:  npc = epc_q;
`endif
                default:  npc = pc_seq;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        pc_q <= npc;
    end

`ifdef PC_TRAP_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            epc_q <= '0;
        end else if (PC_EN && sel == SEL_TRAP) begin
            epc_q <= pc_q;
        end
    end

    assign EPC = epc_q;
`endif

    // RET beats JMP in the select, so CALL alongside RET never pushes.
    assign ras_push = PC_EN && (sel == SEL_JMP) && CALL;
    assign ras_pop  = PC_EN && (sel == SEL_RET);

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .CLK       (CLK),
        .RESET     (RESET),
        .PUSH      (ras_push),
        .POP       (ras_pop),
        .PUSH_DATA (pc_seq),
        .TOP       (ras_top),
        .EMPTY     (ras_empty),
        .FULL      (RAS_FULL),
        .ERR       (RAS_ERR)
    );

    assign PC        = pc_q;
    assign NPC       = npc;
    assign RAS_EMPTY = ras_empty;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    localparam int DEPTH = 4;

    logic        CLK;
    logic        RESET;
    logic        PC_EN;
    logic        BR_TAKEN;
    logic [15:0] BR_OFFSET;
    logic        JMP;
    logic [15:0] JMP_TARGET;
    logic        CALL;
    logic        RET;
    logic [15:0] PC;
    logic [15:0] NPC;
    logic        RAS_EMPTY;
    logic        RAS_FULL;
    logic        RAS_ERR;
`ifdef PC_TRAP_EN
    logic        TRAP;
    logic        RFE;
    logic [15:0] EPC;
`endif

    pc_unit dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .PC_EN      (PC_EN),
        .BR_TAKEN   (BR_TAKEN),
        .BR_OFFSET  (BR_OFFSET),
        .JMP        (JMP),
        .JMP_TARGET (JMP_TARGET),
        .CALL       (CALL),
        .RET        (RET),
`ifdef PC_TRAP_EN
        .TRAP       (TRAP),
        .RFE        (RFE),
        .EPC        (EPC),
`endif
        .PC         (PC),
        .NPC        (NPC),
        .RAS_EMPTY  (RAS_EMPTY),
        .RAS_FULL   (RAS_FULL),
        .RAS_ERR    (RAS_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] epc;
        logic        empty;
        logic        full;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_ras[$];
    logic [15:0] m_pc;
    logic [15:0] m_epc;
    logic        m_err;
    int          n_tests;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, update the reference model, check NPC
    // before the edge and registered state after it via the scoreboard.
    task automatic step(input string tag, input bit rst, input bit en,
                        input bit br, input logic [15:0] off,
                        input bit jmp, input logic [15:0] tgt,
                        input bit call, input bit ret,
                        input bit trap, input bit rfe);
        logic [15:0] n;
        exp_t        e;
        exp_t        got;
        RESET      = rst;
        PC_EN      = en;
        BR_TAKEN   = br;
        BR_OFFSET  = off;
        JMP        = jmp;
        JMP_TARGET = tgt;
        CALL       = call;
        RET        = ret;
`ifdef PC_TRAP_EN
        TRAP       = trap;
        RFE        = rfe;
`endif
        n = m_pc + 16'd1;
        if (rst) begin
            n = 16'h0000;
            m_ras.delete();
            m_err = 1'b0;
            m_epc = 16'h0000;
        end else if (!en) begin
            n = m_pc;
        end else if (trap) begin
            m_epc = m_pc;
            n = 16'h0100;
        end else if (rfe) begin
            n = m_epc;
        end else if (ret) begin
            if (m_ras.size() > 0) n = m_ras.pop_back();
            else m_err = 1'b1;
        end else if (jmp) begin
            n = tgt;
            if (call) begin
                if (m_ras.size() == DEPTH) begin
                    void'(m_ras.pop_front());
                    m_err = 1'b1;
                end
                m_ras.push_back(m_pc + 16'd1);
            end
        end else if (br) begin
            n = m_pc + off;
        end
        #1;
        chk({tag, ".npc"}, {16'h0, NPC}, {16'h0, n});
        e.pc    = n;
        e.epc   = m_epc;
        e.empty = (m_ras.size() == 0);
        e.full  = (m_ras.size() == DEPTH);
        e.err   = m_err;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        got = sb.pop_front();
        m_pc = n;
        chk({tag, ".pc"},    {16'h0, PC},    {16'h0, got.pc});
        chk({tag, ".empty"}, {31'h0, RAS_EMPTY}, {31'h0, got.empty});
        chk({tag, ".full"},  {31'h0, RAS_FULL},  {31'h0, got.full});
        chk({tag, ".err"},   {31'h0, RAS_ERR},   {31'h0, got.err});
`ifdef PC_TRAP_EN
        chk({tag, ".epc"},   {16'h0, EPC},   {16'h0, got.epc});
`endif
    endtask

    task automatic do_rst();                step("rst",  1, 1, 0, 16'h0, 0, 16'h0, 0, 0, 0, 0); endtask
    task automatic do_seq();                step("seq",  0, 1, 0, 16'h0, 0, 16'h0, 0, 0, 0, 0); endtask
    task automatic do_jmp(input logic [15:0] t);  step("jmp",  0, 1, 0, 16'h0, 1, t, 0, 0, 0, 0); endtask
    task automatic do_call(input logic [15:0] t); step("call", 0, 1, 0, 16'h0, 1, t, 1, 0, 0, 0); endtask
    task automatic do_br(input logic [15:0] o);   step("br",   0, 1, 1, o, 0, 16'h0, 0, 0, 0, 0); endtask
    task automatic do_ret();                step("ret",  0, 1, 0, 16'h0, 0, 16'h0, 0, 1, 0, 0); endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_pc    = 16'h0;
        m_epc   = 16'h0;
        m_err   = 1'b0;

        // reset then sequential: PC 0,0,1,2,3,4,5
        do_rst();
        do_rst();
        chk("rst_pc_abs", {16'h0, PC}, 32'h0);
        for (int i = 0; i < 5; i++) do_seq();
        chk("seq_pc_abs", {16'h0, PC}, 32'h5);

        // stall with requests asserted, then branches
        do_jmp(16'h0010);
        step("stall_ret", 0, 0, 0, 16'h0, 0, 16'h0, 0, 1, 1, 1);
        step("stall_call", 0, 0, 1, 16'h4, 1, 16'h0300, 1, 0, 0, 0);
        step("stall_all", 0, 0, 1, 16'h4, 1, 16'h0300, 1, 1, 0, 0);
        chk("stall_pc_abs", {16'h0, PC}, 32'h0010);
        do_br(16'hFFF8);
        chk("br_back_abs", {16'h0, PC}, 32'h0008);
        do_br(16'h0004);
        chk("br_fwd_abs", {16'h0, PC}, 32'h000C);

        // nested call/return
        do_jmp(16'h0020);
        do_call(16'h0100);
        do_call(16'h0200);
        do_ret();
        chk("ret1_abs", {16'h0, PC}, 32'h0101);
        do_ret();
        chk("ret2_abs", {16'h0, PC}, 32'h0021);

        // overflow / underflow
        do_jmp(16'h0010);
        for (int i = 0; i < 5; i++) do_call(16'h0011 + 16'(i));
        chk("ovf_full_abs", {31'h0, RAS_FULL}, 32'h1);
        for (int i = 0; i < 4; i++) do_ret();
        chk("last_ret_abs", {16'h0, PC}, 32'h0012);
        do_ret();
        chk("unf_pc_abs", {16'h0, PC}, 32'h0013);

        // wrap and priority
        do_rst();
        do_jmp(16'hFFFF);
        do_seq();
        chk("wrap_abs", {16'h0, PC}, 32'h0000);
        step("jmp_br", 0, 1, 1, 16'h0010, 1, 16'h0300, 0, 0, 0, 0);
        do_jmp(16'h0041);
        do_call(16'h0500);
        step("ret_jmp_call", 0, 1, 0, 16'h0, 1, 16'h0700, 1, 1, 0, 0);
        chk("ret_prio_abs", {16'h0, PC}, 32'h0042);

        // reset mid-sequence with error set and entries pushed
        do_ret();
        do_call(16'h0600);
        do_call(16'h0650);
        do_rst();
        chk("mid_rst_err_abs", {31'h0, RAS_ERR}, 32'h0);

`ifdef PC_TRAP_EN
        do_jmp(16'h0055);
        step("trap", 0, 1, 1, 16'h4, 1, 16'h0300, 1, 1, 1, 1);
        chk("trap_epc_abs", {16'h0, EPC}, 32'h0055);
        step("rfe", 0, 1, 0, 16'h0, 1, 16'h0300, 0, 1, 0, 1);
        chk("rfe_pc_abs", {16'h0, PC}, 32'h0055);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the Extended DLX fetch stage. Generalises the plain increment-only PC.
- Adds width/reset-vector/step parameters, PC-relative branch, absolute jump, and call/return through an internal return-address stack (RAS).
- Sits between the control unit (redirect requests) and instruction memory (PC output).

Parameters:
- PC_W, 16, PC and address width in bits.
- RESET_VEC, 0, PC value loaded on reset (PC_W bits).
- INC, 1, sequential step added per advance.
- RAS_DEPTH, 4, number of return-stack entries, power of 2, ≥2.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- PC_EN  in  1  advance enable. 0 = stall: PC and RAS hold and all requests are ignored.
- BR_TAKEN  in  1  take relative branch.
- BR_OFFSET  in  PC_W  two's-complement offset, relative to current PC.
- JMP  in  1  absolute jump.
- JMP_TARGET  in  PC_W  jump destination.
- CALL  in  1  qualifies JMP: push PC+INC onto the RAS.
- RET  in  1  pop the RAS top into PC.
- PC  out  PC_W  current PC (registered).
- NPC  out  PC_W  combinational next-PC; equals the value PC takes at the next edge.
- RAS_EMPTY  out  1  RAS holds 0 entries.
- RAS_FULL  out  1  RAS holds RAS_DEPTH entries.
- RAS_ERR  out  1  sticky flag: overflow or underflow has occurred; cleared only by RESET.

Behaviour:
- Reset (synchronous, active-high):
  - PC=RESET_VEC, RAS count=0, RAS_EMPTY=1, RAS_FULL=0, RAS_ERR=0.
  - RESET overrides every other input, including mid-call or mid-return.
- Update priority when PC_EN=1: RET > JMP > BR_TAKEN > sequential.
  - RET, RAS not empty: PC<=top entry; pop; count-1.
  - RET, RAS empty (underflow): PC<=PC+INC; RAS_ERR<=1; count stays 0.
  - JMP: PC<=JMP_TARGET. If CALL=1, also push PC+INC.
  - BR_TAKEN: PC<=PC+BR_OFFSET.
  - Otherwise: PC<=PC+INC.
- Arithmetic: all sums are mod 2^PC_W; PC wraps silently at all-ones.
- CALL without JMP has no effect. CALL with RET: RET wins, no push.
- Push while full (overflow): RAS is circular, so the oldest entry is overwritten; count stays RAS_DEPTH; RAS_ERR<=1.
- Latency:
  - Redirects take effect at the next edge (1 cycle).
  - NPC reflects the same priority combinationally in the same cycle.
  - A pushed value is poppable on the following cycle.
- PC_EN=0:
  - NPC=PC; no RAS change, even when RET or CALL is asserted.
  - RAS_ERR is not set while stalled.
- RAS implementation: top pointer plus count, with registered storage. Flags are derived from the count.

Optional Feature:
- Macro: PC_TRAP_EN.
- When defined, the block adds:
  - Ports: TRAP (in, 1), RFE (in, 1), EPC (out, PC_W).
  - Parameter: TRAP_VEC, default 16'h0100.
- Priority becomes TRAP > RFE > RET > JMP > BR_TAKEN > sequential. TRAP and RFE are honoured only when PC_EN=1.
  - TRAP: EPC<=PC, PC<=TRAP_VEC.
  - RFE: PC<=EPC.
  - The RAS is untouched by both.
- EPC resets to 0.
- When undefined: these ports and logic are absent, and behaviour is exactly as above.

Decomposition:
- Shared package pc_pkg:
  - Default width and vector constants.
  - Next-PC select encoding: SEL_SEQ, SEL_BR, SEL_JMP, SEL_RET, SEL_TRAP, SEL_RFE.
  - RAS pointer-width function (clog2 of RAS_DEPTH).
- One sub-module: pc_ras. It is a parametrised circular LIFO with push/pop/empty/full/err. pc_unit holds the PC register, next-PC mux and priority logic.

Test Plan:
- Reset and sequential: RESET=1 for 2 cycles, then PC_EN=1 for 5 cycles → PC 0,0,1,2,3,4,5 (INC=1); RAS_EMPTY=1.
- Stall and branch: from PC=0x0010, PC_EN=0 for 3 cycles → PC stays 0x0010. Then BR_TAKEN with BR_OFFSET=0xFFF8 → PC=0x0008. Then BR_OFFSET=0x0004 → PC=0x000C.
- Call/return nesting: at PC=0x0020, JMP+CALL to 0x0100. At 0x0100, JMP+CALL to 0x0200. Then RET, RET → PC=0x0101, then 0x0021; RAS_EMPTY=1; RAS_ERR=0.
- RAS boundaries (RAS_DEPTH=4): 5 calls from PCs 0x10..0x14 → RAS_FULL=1, RAS_ERR=1. Then 4 RETs → 0x15,0x14,0x13,0x12 (oldest lost). A 5th RET → PC+1; RAS_ERR stays 1.
- Wrap and priority: PC=0xFFFF, sequential → 0x0000. Same cycle JMP=1 (target 0x0300) and BR_TAKEN=1 (offset 0x0010) → 0x0300. Same cycle RET=1, JMP=1, CALL=1 with RAS top 0x0042 → PC=0x0042, nothing pushed.
- RESET mid-sequence (and, with PC_TRAP_EN, trap): RESET asserted after 2 pushes → PC=RESET_VEC, RAS_EMPTY=1, RAS_ERR=0. With PC_TRAP_EN: TRAP at PC=0x0055 → PC=0x0100, EPC=0x0055; then RFE → PC=0x0055.
